// File: rtl/fc_pkg.sv
// Shared types and helpers for the time-multiplexed fully-connected layer.
package fc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } fc_state_e;

  // Widest value the sign-extension helper handles.
  localparam int SEXT_MAX = 64;

  // Accumulator width that cannot overflow for in_len products of two width-bit operands.
  function automatic int acc_width(input int width, input int in_len);
    return 2 * width + $clog2(in_len) + 1;
  endfunction

  // Replicates bit w-1 of v into every bit above it.
  function automatic logic [SEXT_MAX-1:0] sext(input logic [SEXT_MAX-1:0] v, input int w);
    logic [SEXT_MAX-1:0] mask;
    mask = {SEXT_MAX{1'b1}} << w;
    return ((v & mask) != '0 || (v >> (w - 1)) & 64'd1) != 0 && ((v >> (w - 1)) & 64'd1) != 0
           ? (v | mask) : (v & ~mask);
  endfunction

endpackage

// File: rtl/fc_lane_dot.sv
// LANES-wide signed dot product: one multiplier per lane feeding a balanced adder tree.
module fc_lane_dot #(
  parameter  int LANES = 8,
  parameter  int WIDTH = 8,
  localparam int OW    = 2 * WIDTH + $clog2(LANES) + 1
) (
  input  logic [LANES*WIDTH-1:0] x_i,
  input  logic [LANES*WIDTH-1:0] w_i,
  output logic signed [OW-1:0]   dot_o
);

  // Tree is padded to a power of two so every level pairs cleanly.
  localparam int P = 1 << $clog2(LANES);

  // Heap-ordered tree: leaves at P-1.., node i sums children 2i+1 and 2i+2.
  always_comb begin
    logic signed [OW-1:0]      node [2*P-1];
    logic signed [2*WIDTH-1:0] prod;
    for (int i = 0; i < 2 * P - 1; i++) node[i] = '0;
    for (int l = 0; l < LANES; l++) begin
      prod = $signed(x_i[l*WIDTH +: WIDTH]) * $signed(w_i[l*WIDTH +: WIDTH]);
      node[P-1+l] = OW'(prod);
    end
    for (int i = P - 2; i >= 0; i--) node[i] = node[2*i+1] + node[2*i+2];
    dot_o = node[0];
  end

endmodule

// File: rtl/fc_mac_layer.sv
// Runtime-programmable fully-connected layer: buffers one input vector, then
// evaluates OUT neurons serially, LANES products per cycle, bias + optional ReLU.
module fc_mac_layer
  import fc_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int IN    = 128,
  parameter  int OUT   = 10,
  parameter  int LANES = 8,
  parameter  int RELU  = 1,
  localparam int ACC_W = acc_width(WIDTH, IN),
  localparam int NW    = (OUT > 1) ? $clog2(OUT) : 1,
  localparam int IW    = (IN > 1) ? $clog2(IN) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*WIDTH-1:0] s_data,
  input  logic                   w_we,
  input  logic [NW-1:0]          w_neuron,
  input  logic [IW-1:0]          w_index,
  input  logic [WIDTH-1:0]       w_data,
  input  logic                   b_we,
  output logic                   busy,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [ACC_W-1:0]       m_data,
  output logic                   m_last
);

  localparam int BEATS = IN / LANES;
  localparam int BW    = $clog2(BEATS + 1);
  localparam int XIW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW    = 2 * WIDTH + $clog2(LANES) + 1;

  if (IN % LANES != 0) begin : g_bad_cfg
    $error("fc_mac_layer: IN must be a multiple of LANES");
  end

  logic [WIDTH-1:0]       wmem_q [OUT][IN];
  logic [WIDTH-1:0]       bmem_q [OUT];
  logic [LANES*WIDTH-1:0] xbuf_q [BEATS];

  fc_state_e               st_q;
  logic [BW-1:0]           beat_q;
  logic [NW-1:0]           neuron_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, res_d;
  logic                    s_ready_q, m_valid_q, m_last_q;
  logic [ACC_W-1:0]        m_data_q;

  int                      beat_rd;
  logic [LANES*WIDTH-1:0]  x_row, w_row;
  logic signed [DW-1:0]    dot;

  assign busy    = (st_q != ST_IDLE) || (beat_q != '0);
  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

  // Select the input beat and matching weight slice for the current compute cycle.
  always_comb begin
    beat_rd = (int'(beat_q) < BEATS) ? int'(beat_q) : 0;
    x_row   = xbuf_q[XIW'(beat_rd)];
    w_row   = '0;
    for (int l = 0; l < LANES; l++)
      w_row[l*WIDTH +: WIDTH] = wmem_q[neuron_q][IW'(beat_rd * LANES + l)];
  end

  fc_lane_dot #(.LANES(LANES), .WIDTH(WIDTH)) u_dot (
    .x_i  (x_row),
    .w_i  (w_row),
    .dot_o(dot)
  );

  // Next accumulator value and the biased, optionally rectified neuron result.
  always_comb begin
    acc_d = acc_q + ACC_W'(sext(SEXT_MAX'(dot), DW));
    res_d = acc_q + ACC_W'(sext(SEXT_MAX'(bmem_q[neuron_q]), WIDTH));
    if (RELU != 0 && res_d[ACC_W-1]) res_d = '0;
  end

  // Weight/bias programming (only while idle) and input-vector capture; storage is never reset.
  always_ff @(posedge clk) begin
    if (!busy) begin
      if (w_we && int'(w_neuron) < OUT && int'(w_index) < IN) wmem_q[w_neuron][w_index] <= w_data;
      if (b_we && int'(w_neuron) < OUT) bmem_q[w_neuron] <= w_data;
    end
    if (st_q == ST_IDLE && s_valid && s_ready_q) xbuf_q[XIW'(beat_q)] <= s_data;
  end

  // Sequencer: capture BEATS input beats, then per neuron BEATS accumulate cycles
  // plus one cycle to register the result, then hold it until downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      beat_q    <= '0;
      neuron_q  <= '0;
      acc_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          s_ready_q <= 1'b1;
          if (s_valid && s_ready_q) begin
            if (beat_q == BW'(BEATS - 1)) begin
              beat_q    <= '0;
              neuron_q  <= '0;
              acc_q     <= '0;
              s_ready_q <= 1'b0;
              st_q      <= ST_COMPUTE;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          if (beat_q == BW'(BEATS)) begin
            m_data_q  <= res_d;
            m_valid_q <= 1'b1;
            m_last_q  <= (int'(neuron_q) == OUT - 1);
            beat_q    <= '0;
            st_q      <= ST_OUTPUT;
          end else begin
            acc_q  <= acc_d;
            beat_q <= beat_q + 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            acc_q     <= '0;
            beat_q    <= '0;
            if (int'(neuron_q) == OUT - 1) begin
              neuron_q  <= '0;
              s_ready_q <= 1'b1;
              st_q      <= ST_IDLE;
            end else begin
              neuron_q <= neuron_q + 1'b1;
              st_q     <= ST_COMPUTE;
            end
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mac_layer.sv
// Scoreboard bench: two instances (ReLU on / off) share stimulus; a reference
// model pushes expected results when a vector is sent, a monitor pops on handshake.
module tb_fc_mac_layer;

  localparam int WIDTH = 8;
  localparam int IN    = 8;
  localparam int LANES = 4;
  localparam int OUT   = 2;
  localparam int BEATS = IN / LANES;
  localparam int ACC_W = 2 * WIDTH + $clog2(IN) + 1;

  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, w_we = 1'b0, b_we = 1'b0, m_ready = 1'b1;
  logic [LANES*WIDTH-1:0] s_data = '0;
  logic [0:0]             w_neuron = '0;
  logic [2:0]             w_index = '0;
  logic [WIDTH-1:0]       w_data = '0;
  logic s_ready1, s_ready0, busy1, busy0, m_valid1, m_valid0, m_last1, m_last0;
  logic [ACC_W-1:0] m_data1, m_data0;

  always #5 clk = ~clk;

  fc_mac_layer #(.WIDTH(WIDTH), .IN(IN), .OUT(OUT), .LANES(LANES), .RELU(1)) dut_relu (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .w_we(w_we), .w_neuron(w_neuron), .w_index(w_index), .w_data(w_data), .b_we(b_we),
    .busy(busy1), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1));

  fc_mac_layer #(.WIDTH(WIDTH), .IN(IN), .OUT(OUT), .LANES(LANES), .RELU(0)) dut_lin (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .w_we(w_we), .w_neuron(w_neuron), .w_index(w_index), .w_data(w_data), .b_we(b_we),
    .busy(busy0), .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_last(m_last0));

  typedef struct {
    longint r1;
    longint r0;
    logic   last;
  } exp_t;

  exp_t q[$];
  int   wm [OUT][IN];
  int   bm [OUT];
  int   xv [IN];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input int n, input int i, input int v);
    w_we = 1'b1; w_neuron = 1'(n); w_index = 3'(i); w_data = 8'(v);
    tick();
    w_we = 1'b0;
    wm[n][i] = v;
  endtask

  task automatic wr_b(input int n, input int v);
    b_we = 1'b1; w_neuron = 1'(n); w_data = 8'(v);
    tick();
    b_we = 1'b0;
    bm[n] = v;
  endtask

  task automatic wr_wb(input int n, input int i, input int v);
    w_we = 1'b1; b_we = 1'b1; w_neuron = 1'(n); w_index = 3'(i); w_data = 8'(v);
    tick();
    w_we = 1'b0; b_we = 1'b0;
    wm[n][i] = v;
    bm[n] = v;
  endtask

  task automatic set_row(input int n, input int v);
    for (int i = 0; i < IN; i++) wr_w(n, i, v);
  endtask

  task automatic send_beat(input int b);
    bit ok;
    for (int l = 0; l < LANES; l++) s_data[l*WIDTH +: WIDTH] = WIDTH'(xv[b*LANES+l]);
    s_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (s_ready1) ok = 1'b1;
    end
    if (!ok) chk_eq("s_ready_timeout", ok, 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_vec();
    exp_t   e;
    longint r;
    for (int n = 0; n < OUT; n++) begin
      r = bm[n];
      for (int k = 0; k < IN; k++) r += longint'(wm[n][k]) * longint'(xv[k]);
      e.r0 = r;
      e.r1 = (r < 0) ? 0 : r;
      e.last = (n == OUT - 1);
      q.push_back(e);
    end
    for (int b = 0; b < BEATS; b++) send_beat(b);
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    for (int t = 1; t <= 50; t++) begin
      tick();
      if (m_valid1) begin
        k = t;
        break;
      end
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && q.size() != 0; t++) tick();
    chk_eq("drain_pending", q.size(), 0);
  endtask

  // Scoreboard: compare both instances on every accepted result.
  always @(negedge clk) begin
    if (!rst && m_valid1 && m_ready) begin
      if (q.size() == 0) begin
        chk_eq("unexpected_result", q.size(), 1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk_eq("result_relu", longint'($signed(m_data1)), e.r1);
        chk_eq("result_lin", longint'($signed(m_data0)), e.r0);
        chk_eq("valid_lin", m_valid0, 1);
        chk_eq("last_relu", m_last1, e.last);
        chk_eq("last_lin", m_last0, e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset values
    tick(); tick();
    chk_eq("rst_m_valid", m_valid1, 0);
    chk_eq("rst_m_data", m_data1, 0);
    chk_eq("rst_m_last", m_last1, 0);
    chk_eq("rst_s_ready", s_ready1, 0);
    chk_eq("rst_busy", busy1, 0);
    rst = 1'b0;
    tick();
    chk_eq("idle_s_ready", s_ready1, 1);

    // 1: all-ones weights, x = 1..8, latency and m_last
    set_row(0, 1); set_row(1, 1); wr_b(0, 0); wr_b(1, 0);
    for (int i = 0; i < IN; i++) xv[i] = i + 1;
    send_vec();
    chk_eq("busy_compute", busy1, 1);
    chk_eq("s_ready_compute", s_ready1, 0);
    wait_valid(k);
    chk_eq("first_latency", k, BEATS + 1);
    drain();

    // 2: negative row, ReLU vs pass-through
    set_row(0, -1); wr_b(0, 5);
    for (int i = 0; i < IN; i++) xv[i] = 10;
    send_vec();
    drain();

    // 3: extremes
    set_row(0, -128); set_row(1, -128); wr_b(0, 127); wr_b(1, 127);
    for (int i = 0; i < IN; i++) xv[i] = -128;
    send_vec();
    drain();

    // 4: back-pressure holds output; s_valid in OUTPUT is not consumed
    for (int i = 0; i < IN; i++) wr_w(0, i, i - 3);
    set_row(1, 3); wr_b(0, -7); wr_b(1, 4);
    for (int i = 0; i < IN; i++) xv[i] = 5 * i - 17;
    m_ready = 1'b0;
    send_vec();
    wait_valid(k);
    s_data = 32'hdeadbeef;
    s_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      chk_eq("hold_valid", m_valid1, 1);
      chk_eq("hold_data", longint'($signed(m_data1)), q[0].r1);
      chk_eq("hold_s_ready", s_ready1, 0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    drain();
    for (int i = 0; i < IN; i++) xv[i] = 3 - 2 * i;
    send_vec();
    drain();

    // 5: writes while busy are ignored; writes in IDLE (incl. both strobes) take effect
    set_row(0, 1); set_row(1, 1); wr_b(0, 0); wr_b(1, 0);
    for (int i = 0; i < IN; i++) xv[i] = i + 1;
    send_vec();
    chk_eq("busy_during_write", busy1, 1);
    w_we = 1'b1; b_we = 1'b1; w_neuron = 1'b0; w_index = 3'd0; w_data = 8'd100;
    tick();
    w_we = 1'b0; b_we = 1'b0;
    drain();
    send_vec();
    drain();
    wr_w(0, 0, 100);
    wr_wb(1, 7, 9);
    send_vec();
    drain();

    // 6: reset after one beat discards the partial vector
    for (int i = 0; i < IN; i++) xv[i] = 50 + i;
    send_beat(0);
    chk_eq("busy_partial", busy1, 1);
    rst = 1'b1;
    tick();
    chk_eq("mid_rst_m_valid", m_valid1, 0);
    chk_eq("mid_rst_m_data", m_data1, 0);
    chk_eq("mid_rst_m_last", m_last1, 0);
    chk_eq("mid_rst_s_ready", s_ready1, 0);
    chk_eq("mid_rst_busy", busy1, 0);
    rst = 1'b0;
    tick();
    chk_eq("post_rst_m_data", m_data1, 0);
    chk_eq("post_rst_s_ready", s_ready1, 1);
    for (int i = 0; i < IN; i++) xv[i] = 2 * i - 5;
    send_vec();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
